// File: rtl/ps2_host_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Holds the FSM states, error codes, keyboard commands and frame helpers.
package ps2_host_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      INHIBIT    = 3'd1,
      REQ        = 3'd2,
      WAIT_START = 3'd3,
      XFER       = 3'd4,
      ACK        = 3'd5,
      WAIT_IDLE  = 3'd6
   } ps2_state_t;

   localparam logic [1:0] ERR_NONE         = 2'd0;
   localparam logic [1:0] ERR_NO_START     = 2'd1;
   localparam logic [1:0] ERR_NACK         = 2'd2;
   localparam logic [1:0] ERR_XFER_TIMEOUT = 2'd3;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;

   // Wide enough for the 15 ms start timeout at 50 MHz.
   localparam int CNT_W = 20;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

   // Bits shifted out after the start bit: data LSB first, parity, stop.
   function automatic logic [9:0] build_frame(input logic [7:0] data);
      return {1'b1, odd_parity(data), data};
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins, plus a
// falling-edge flag on the synchronized clock. Shared with the receiver.
module ps2_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic clk_pin,
   input  logic dat_pin,
   output logic clk_sync,
   output logic dat_sync,
   output logic clk_fall
);

   logic clk_meta_r;
   logic clk_sync_r;
   logic clk_prev_r;
   logic dat_meta_r;
   logic dat_sync_r;

   // Idle bus level is high, so the pipeline resets to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_meta_r <= 1'b1;
         clk_sync_r <= 1'b1;
         clk_prev_r <= 1'b1;
         dat_meta_r <= 1'b1;
         dat_sync_r <= 1'b1;
      end else begin
         clk_meta_r <= clk_pin;
         clk_sync_r <= clk_meta_r;
         clk_prev_r <= clk_sync_r;
         dat_meta_r <= dat_pin;
         dat_sync_r <= dat_meta_r;
      end
   end

   assign clk_sync = clk_sync_r;
   assign dat_sync = dat_sync_r;
   assign clk_fall = clk_prev_r & ~clk_sync_r;

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 byte transmitter: inhibits the bus, issues a request
// to send, shifts a frame out on device falling edges and checks the ack.
module ps2_host_transmitter
   import ps2_host_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int SETUP_CYCLES   = 250,
   parameter int START_TIMEOUT  = 750000,
   parameter int XFER_TIMEOUT   = 100000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       send_valid,
   input  logic [7:0] send_data,
   output logic       send_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_drive_low,
   output logic       ps2_dat_drive_low,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] error_code
);

   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] XFER_LAST    = CNT_W'(XFER_TIMEOUT - 1);

   ps2_state_t       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [3:0]       bitcnt_r;
   logic [9:0]       frame_r;

   logic clk_sync_s;
   logic dat_sync_s;
   logic clk_fall_s;

   ps2_line_sync u_line_sync (
      .clk      (CLOCK_50),
      .rst_n    (resetn),
      .clk_pin  (ps2_clk_in),
      .dat_pin  (ps2_dat_in),
      .clk_sync (clk_sync_s),
      .dat_sync (dat_sync_s),
      .clk_fall (clk_fall_s)
   );

   // Transmit sequencer; every output is a flop so reset releases the pins at once.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_r           <= IDLE;
         cnt_r             <= {CNT_W{1'b0}};
         bitcnt_r          <= 4'd0;
         frame_r           <= 10'd0;
         send_ready        <= 1'b1;
         busy              <= 1'b0;
         done              <= 1'b0;
         error             <= 1'b0;
         error_code        <= ERR_NONE;
         ps2_clk_drive_low <= 1'b0;
         ps2_dat_drive_low <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state_r)
            IDLE: begin
               if (send_valid) begin
                  frame_r           <= build_frame(send_data);
                  error_code        <= ERR_NONE;
                  cnt_r             <= {CNT_W{1'b0}};
                  bitcnt_r          <= 4'd0;
                  ps2_clk_drive_low <= 1'b1;
                  send_ready        <= 1'b0;
                  busy              <= 1'b1;
                  state_r           <= INHIBIT;
               end else begin
                  ps2_clk_drive_low <= 1'b0;
                  ps2_dat_drive_low <= 1'b0;
               end
            end
            INHIBIT: begin
               if (cnt_r == INHIBIT_LAST) begin
                  cnt_r             <= {CNT_W{1'b0}};
                  ps2_dat_drive_low <= 1'b1;
                  state_r           <= REQ;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            REQ: begin
               if (cnt_r == SETUP_LAST) begin
                  cnt_r             <= {CNT_W{1'b0}};
                  ps2_clk_drive_low <= 1'b0;
                  state_r           <= WAIT_START;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            WAIT_START: begin
               if (clk_fall_s) begin
                  ps2_dat_drive_low <= ~frame_r[0];
                  bitcnt_r          <= 4'd1;
                  cnt_r             <= {CNT_W{1'b0}};
                  state_r           <= XFER;
               end else if (cnt_r >= START_LAST) begin
                  ps2_clk_drive_low <= 1'b0;
                  ps2_dat_drive_low <= 1'b0;
                  error             <= 1'b1;
                  error_code        <= ERR_NO_START;
                  send_ready        <= 1'b1;
                  busy              <= 1'b0;
                  state_r           <= IDLE;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            XFER: begin
               // An edge in the expiry cycle still wins; >= catches the overshoot.
               if (clk_fall_s) begin
                  cnt_r <= cnt_r + 1'b1;
                  if (bitcnt_r == 4'd10) begin
                     state_r <= ACK;
                  end else begin
                     ps2_dat_drive_low <= ~frame_r[bitcnt_r];
                     bitcnt_r          <= bitcnt_r + 4'd1;
                  end
               end else if (cnt_r >= XFER_LAST) begin
                  ps2_clk_drive_low <= 1'b0;
                  ps2_dat_drive_low <= 1'b0;
                  error             <= 1'b1;
                  error_code        <= ERR_XFER_TIMEOUT;
                  send_ready        <= 1'b1;
                  busy              <= 1'b0;
                  state_r           <= IDLE;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            ACK: begin
               cnt_r <= cnt_r + 1'b1;
               if (!dat_sync_s) begin
                  state_r <= WAIT_IDLE;
               end else begin
                  ps2_clk_drive_low <= 1'b0;
                  ps2_dat_drive_low <= 1'b0;
                  error             <= 1'b1;
                  error_code        <= ERR_NACK;
                  send_ready        <= 1'b1;
                  busy              <= 1'b0;
                  state_r           <= IDLE;
               end
            end
            WAIT_IDLE: begin
               if (clk_sync_s && dat_sync_s) begin
                  done       <= 1'b1;
                  send_ready <= 1'b1;
                  busy       <= 1'b0;
                  state_r    <= IDLE;
               end else if (cnt_r >= XFER_LAST) begin
                  ps2_clk_drive_low <= 1'b0;
                  ps2_dat_drive_low <= 1'b0;
                  error             <= 1'b1;
                  error_code        <= ERR_XFER_TIMEOUT;
                  send_ready        <= 1'b1;
                  busy              <= 1'b0;
                  state_r           <= IDLE;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            default: begin
               ps2_clk_drive_low <= 1'b0;
               ps2_dat_drive_low <= 1'b0;
               send_ready        <= 1'b1;
               busy              <= 1'b0;
               state_r           <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Self-checking bench: open-collector device model clocking at a 40-cycle
// period, table of bytes with expected parity, and an outcome scoreboard.
module tb_ps2_host_transmitter;

   localparam int P_INH   = 10;
   localparam int P_SET   = 3;
   localparam int P_START = 200;
   localparam int P_XFER  = 2000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       send_valid;
   logic [7:0] send_data;
   logic       send_ready;
   logic       ps2_clk_in;
   logic       ps2_dat_in;
   logic       ps2_clk_drive_low;
   logic       ps2_dat_drive_low;
   logic       busy;
   logic       done;
   logic       error;
   logic [1:0] error_code;

   logic dev_clk_low = 1'b0;
   logic dev_dat_low = 1'b0;

   assign ps2_clk_in = ~(ps2_clk_drive_low | dev_clk_low);
   assign ps2_dat_in = ~(ps2_dat_drive_low | dev_dat_low);

   ps2_host_transmitter #(
      .INHIBIT_CYCLES (P_INH),
      .SETUP_CYCLES   (P_SET),
      .START_TIMEOUT  (P_START),
      .XFER_TIMEOUT   (P_XFER)
   ) dut (
      .CLOCK_50          (clk),
      .resetn            (rst_n),
      .send_valid        (send_valid),
      .send_data         (send_data),
      .send_ready        (send_ready),
      .ps2_clk_in        (ps2_clk_in),
      .ps2_dat_in        (ps2_dat_in),
      .ps2_clk_drive_low (ps2_clk_drive_low),
      .ps2_dat_drive_low (ps2_dat_drive_low),
      .busy              (busy),
      .done              (done),
      .error             (error),
      .error_code        (error_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] frame;
      logic [1:0]  code;
      logic        is_done;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic       parity;
   } vec_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          outcomes = 0;
   logic [10:0] cap_bits = 11'd0;
   int          first_fall_cyc = 0;
   int          err_cyc = 0;
   int          inhibit_cnt = 0;
   int          setup_cnt = 0;
   int          wstart_cnt = 0;
   logic        snap_clk = 1'b0;
   logic        snap_dat = 1'b0;
   logic        snap_ready = 1'b0;
   vec_t        vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: line-phase counters and scoreboard pop on done/error pulses.
   initial forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
         if (ps2_clk_drive_low && !ps2_dat_drive_low) inhibit_cnt++;
         if (ps2_clk_drive_low && ps2_dat_drive_low) setup_cnt++;
         if (!ps2_clk_drive_low && ps2_dat_drive_low && busy) wstart_cnt++;
         if (done || error) begin
            outcomes++;
            err_cyc    = cyc;
            snap_clk   = ps2_clk_drive_low;
            snap_dat   = ps2_dat_drive_low;
            snap_ready = send_ready;
            if (sb_q.size() == 0) begin
               check("unexpected_outcome", {30'd0, done, error}, 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               check("outcome_done_error", {30'd0, done, error}, mon_e.is_done ? 32'd2 : 32'd1);
               check("error_code", {30'd0, error_code}, {30'd0, mon_e.code});
               if (mon_e.is_done) check("frame_bits", {21'd0, cap_bits}, {21'd0, mon_e.frame});
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] d);
      @(negedge clk);
      check("send_ready_before_send", {31'd0, send_ready}, 32'd1);
      inhibit_cnt = 0;
      setup_cnt   = 0;
      wstart_cnt  = 0;
      send_data   = d;
      send_valid  = 1'b1;
      @(negedge clk);
      send_valid = 1'b0;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
   endtask

   // Device: waits for request-to-send, then clocks up to edges_max falling edges.
   task automatic device(input int edges_max, input bit ack);
      bit seen;
      seen = 1'b0;
      for (int w = 0; w < 100; w++) begin
         @(negedge clk);
         if (!ps2_clk_drive_low && ps2_dat_drive_low) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         check("request_to_send_seen", 32'd0, 32'd1);
      end else begin
         cap_bits[0] = ps2_dat_in;
         for (int e = 1; e <= 11; e++) begin
            if (e > edges_max) break;
            repeat (10) @(negedge clk);
            if (e == 11 && ack) dev_dat_low = 1'b1;
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b1;
            if (e == 1) first_fall_cyc = cyc;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            if (e <= 10) cap_bits[e] = ps2_dat_in;
            if (e == 11) dev_dat_low = 1'b0;
         end
      end
   endtask

   task automatic wait_outcome(input int target, input int budget);
      bit got;
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (outcomes >= target) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("outcome_timeout", outcomes, target);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   prev;
      exp_t e;
      vecs[0] = '{8'hED, 1'b1};
      vecs[1] = '{8'h00, 1'b1};
      vecs[2] = '{8'h01, 1'b0};
      vecs[3] = '{8'hFF, 1'b1};
      vecs[4] = '{8'h80, 1'b0};
      vecs[5] = '{8'hF4, 1'b0};

      rst_n      = 1'b0;
      send_valid = 1'b0;
      send_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_send_ready", {31'd0, send_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done_error", {30'd0, done, error}, 32'd0);
      check("rst_error_code", {30'd0, error_code}, 32'd0);
      check("rst_drives", {30'd0, ps2_clk_drive_low, ps2_dat_drive_low}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         e.frame   = {1'b1, vecs[i].parity, vecs[i].data, 1'b0};
         e.code    = 2'd0;
         e.is_done = 1'b1;
         sb_q.push_back(e);
         send_byte(vecs[i].data);
         if (i == 0) begin
            @(negedge clk);
            send_data  = 8'h55;
            send_valid = 1'b1;
            @(negedge clk);
            send_valid = 1'b0;
         end
         device(11, 1'b1);
         wait_outcome(i + 1, 100);
         check("parity_bit", {31'd0, cap_bits[9]}, {31'd0, vecs[i].parity});
         if (i == 0) begin
            check("inhibit_cycles", inhibit_cnt, P_INH);
            check("setup_cycles", setup_cnt, P_SET);
            repeat (5) @(negedge clk);
            check("no_queued_send_busy", {31'd0, busy}, 32'd0);
            check("no_queued_send_clk", {31'd0, ps2_clk_drive_low}, 32'd0);
         end
      end

      // Device never clocks.
      e.frame = 11'd0; e.code = 2'd1; e.is_done = 1'b0;
      sb_q.push_back(e);
      send_byte(8'h55);
      wait_outcome(7, 400);
      check("nostart_cycles", wstart_cnt, P_START);
      check("nostart_drives", {30'd0, snap_clk, snap_dat}, 32'd0);
      check("nostart_ready", {31'd0, snap_ready}, 32'd1);

      // Device withholds the ack.
      e.code = 2'd2;
      sb_q.push_back(e);
      send_byte(8'hF4);
      device(11, 1'b0);
      wait_outcome(8, 100);
      check("nack_drives", {30'd0, snap_clk, snap_dat}, 32'd0);

      // Device stalls after bit 3.
      e.code = 2'd3;
      sb_q.push_back(e);
      send_byte(8'hFF);
      device(4, 1'b1);
      wait_outcome(9, 2500);
      check("xfer_timeout_cycles", err_cyc - first_fall_cyc, 3 + P_XFER);
      check("xfer_timeout_drives", {30'd0, snap_clk, snap_dat}, 32'd0);

      // Reset while bit 4 (a 0 for 0xED) is on the line.
      send_byte(8'hED);
      device(5, 1'b1);
      check("bit4_driven_low", {31'd0, ps2_dat_drive_low}, 32'd1);
      prev = outcomes;
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_drives", {30'd0, ps2_clk_drive_low, ps2_dat_drive_low}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      check("abort_no_pulse", outcomes, prev);
      check("after_rst_ready", {31'd0, send_ready}, 32'd1);

      // Fresh transfer after the abort.
      e.frame = {1'b1, 1'b1, 8'h3C, 1'b0}; e.code = 2'd0; e.is_done = 1'b1;
      sb_q.push_back(e);
      send_byte(8'h3C);
      device(11, 1'b1);
      wait_outcome(prev + 1, 100);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
